// File: rtl/player_input_arbiter_pkg.sv
// Shared reaction-game definitions: round states, winner codes and
// board timing constants used by the input front end and clock dividers.
package player_input_arbiter_pkg;

  localparam int unsigned CLK_HZ                  = 50_000_000;
  localparam int unsigned DEBOUNCE_MS             = 5;
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;

  typedef enum logic [1:0] {
    WAIT    = 2'd0,
    ARMED   = 2'd1,
    DECIDED = 2'd2
  } game_state_t;

  typedef logic [1:0] winner_t;

  localparam winner_t WIN_NONE = 2'b00;
  localparam winner_t WIN_P1   = 2'b01;
  localparam winner_t WIN_P2   = 2'b10;
  localparam winner_t WIN_TIE  = 2'b11;

  // Clean single-cycle events delivered by the three input channels.
  typedef struct packed {
    logic p1;
    logic p2;
    logic start;
  } input_events_t;

endpackage

// File: rtl/debounce_channel.sv
// One raw board input: 2-flop synchronizer, stability counter and
// registered edge pulses on the accepted (stable) value.
module debounce_channel
  import player_input_arbiter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic        IDLE_LEVEL      = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic stable_out,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_meta;
  logic          sync_out;
  logic [CW-1:0] count;
  logic          accept;

  assign accept = (sync_out != stable_out) && (count == CNT_LAST);

  // Synchronizer resets to the idle level so release never fakes an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= IDLE_LEVEL;
      sync_out  <= IDLE_LEVEL;
    end else begin
      sync_meta <= raw_in;
      sync_out  <= sync_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_out <= IDLE_LEVEL;
      count      <= '0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= accept & sync_out;
      fall_pulse <= accept & ~sync_out;
      if (sync_out == stable_out) begin
        count <= '0;
      end else if (count == CNT_LAST) begin
        stable_out <= sync_out;
        count      <= '0;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/player_input_arbiter.sv
// Reaction-game input front end: debounced player switches and start
// button, false-start detection and first-to-flip round arbitration.
module player_input_arbiter
  import player_input_arbiter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sw_p1,
  input  logic       sw_p2,
  input  logic       btn_start_n,
  input  logic       armed,
  input  logic       clear,
  output logic       start_pulse,
  output logic       p1_hit,
  output logic       p2_hit,
  output logic       p1_false,
  output logic       p2_false,
  output logic [1:0] winner,
  output logic       decided
);

  logic p1_stable, p1_rise, p1_fall;
  logic p2_stable, p2_rise, p2_fall;
  logic btn_stable, btn_rise, btn_fall;
  input_events_t ev;

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .IDLE_LEVEL(1'b0)) u_p1 (
    .clk(clk), .reset(reset), .raw_in(sw_p1),
    .stable_out(p1_stable), .rise_pulse(p1_rise), .fall_pulse(p1_fall)
  );

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .IDLE_LEVEL(1'b0)) u_p2 (
    .clk(clk), .reset(reset), .raw_in(sw_p2),
    .stable_out(p2_stable), .rise_pulse(p2_rise), .fall_pulse(p2_fall)
  );

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .IDLE_LEVEL(1'b1)) u_btn (
    .clk(clk), .reset(reset), .raw_in(btn_start_n),
    .stable_out(btn_stable), .rise_pulse(btn_rise), .fall_pulse(btn_fall)
  );

  // Switches count only when turned on; the button only when pressed.
  assign ev.p1    = p1_rise;
  assign ev.p2    = p2_rise;
  assign ev.start = btn_fall;

  logic unused_chan;
  assign unused_chan = ^{p1_stable, p1_fall, p2_stable, p2_fall, btn_stable, btn_rise};

  game_state_t state, state_next;
  winner_t     winner_next;
  logic        decided_next;
  logic        start_next, p1_hit_next, p2_hit_next, p1_false_next, p2_false_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= WAIT;
      winner      <= WIN_NONE;
      decided     <= 1'b0;
      start_pulse <= 1'b0;
      p1_hit      <= 1'b0;
      p2_hit      <= 1'b0;
      p1_false    <= 1'b0;
      p2_false    <= 1'b0;
    end else begin
      state       <= state_next;
      winner      <= winner_next;
      decided     <= decided_next;
      start_pulse <= start_next;
      p1_hit      <= p1_hit_next;
      p2_hit      <= p2_hit_next;
      p1_false    <= p1_false_next;
      p2_false    <= p2_false_next;
    end
  end

  // Re-arm (clear or start press) outranks any same-cycle switch event.
  always_comb begin
    state_next    = state;
    winner_next   = winner;
    decided_next  = decided;
    start_next    = ev.start;
    p1_hit_next   = 1'b0;
    p2_hit_next   = 1'b0;
    p1_false_next = 1'b0;
    p2_false_next = 1'b0;
    if (clear || ev.start) begin
      state_next   = WAIT;
      winner_next  = WIN_NONE;
      decided_next = 1'b0;
    end else begin
      case (state)
        WAIT: begin
          p1_false_next = ev.p1;
          p2_false_next = ev.p2;
          if (armed) state_next = ARMED;
        end
        ARMED: begin
          if (!armed) begin
            state_next = WAIT;
          end else if (ev.p1 && ev.p2) begin
            winner_next  = WIN_TIE;
            decided_next = 1'b1;
            state_next   = DECIDED;
          end else if (ev.p1) begin
            p1_hit_next  = 1'b1;
            winner_next  = WIN_P1;
            decided_next = 1'b1;
            state_next   = DECIDED;
          end else if (ev.p2) begin
            p2_hit_next  = 1'b1;
            winner_next  = WIN_P2;
            decided_next = 1'b1;
            state_next   = DECIDED;
          end
        end
        DECIDED: begin
          state_next = DECIDED;
        end
        default: begin
          state_next = WAIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_player_input_arbiter.sv
// Randomized and directed checks of player_input_arbiter against a
// window-based debounce model and a round-rules model.
module tb_player_input_arbiter;

  localparam int unsigned DC = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sw_p1 = 1'b0;
  logic       sw_p2 = 1'b0;
  logic       btn_start_n = 1'b1;
  logic       armed = 1'b0;
  logic       clear = 1'b0;
  logic       start_pulse, p1_hit, p2_hit, p1_false, p2_false, decided;
  logic [1:0] winner;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  player_input_arbiter #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .sw_p1(sw_p1), .sw_p2(sw_p2),
    .btn_start_n(btn_start_n), .armed(armed), .clear(clear),
    .start_pulse(start_pulse), .p1_hit(p1_hit), .p2_hit(p2_hit),
    .p1_false(p1_false), .p2_false(p2_false), .winner(winner), .decided(decided)
  );

  logic [7:0] obs;
  assign obs = {start_pulse, p1_hit, p2_hit, p1_false, p2_false, winner, decided};

  // Reference: a raw value is accepted once DC consecutive synced samples
  // (raw delayed by two edges) all disagree with the accepted value.
  logic [DC+1:0] m_hist [3];
  logic [2:0]    m_stable;
  logic [2:0]    m_ev;
  int            m_phase;
  logic [7:0]    exp_v;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hist[0] <= '0;
      m_hist[1] <= '0;
      m_hist[2] <= '1;
      m_stable  <= 3'b100;
      m_ev      <= 3'b000;
      m_phase   <= 0;
      exp_v     <= 8'h00;
    end else begin : step
      automatic logic [2:0]    raw = {btn_start_n, sw_p2, sw_p1};
      automatic logic [2:0]    st = m_stable;
      automatic logic [2:0]    ev = 3'b000;
      automatic logic [DC+1:0] h;
      automatic logic [DC-1:0] win;
      automatic int            ph = m_phase;
      automatic logic [1:0]    w = exp_v[2:1];
      automatic logic          d = exp_v[0];
      automatic logic          s, h1 = 1'b0, h2 = 1'b0, f1 = 1'b0, f2 = 1'b0;
      for (int i = 0; i < 3; i++) begin
        h = {m_hist[i][DC:0], raw[i]};
        m_hist[i] <= h;
        win = h[DC+1:2];
        if ((st[i] && win == '0) || (!st[i] && win == '1)) begin
          st[i] = ~st[i];
          ev[i] = (i == 2) ? ~st[i] : st[i];
        end
      end
      s = m_ev[2];
      if (clear || m_ev[2]) begin
        ph = 0; w = 2'b00; d = 1'b0;
      end else if (ph == 0) begin
        f1 = m_ev[0]; f2 = m_ev[1];
        if (armed) ph = 1;
      end else if (ph == 1) begin
        if (!armed) ph = 0;
        else if (m_ev[0] || m_ev[1]) begin
          w  = {m_ev[1], m_ev[0]};
          d  = 1'b1;
          ph = 2;
          h1 = m_ev[0] & ~m_ev[1];
          h2 = m_ev[1] & ~m_ev[0];
        end
      end
      m_stable <= st;
      m_ev     <= ev;
      m_phase  <= ph;
      exp_v    <= {s, h1, h2, f1, f2, w, d};
    end
  end

  task automatic do_reset(input logic arm);
    @(negedge clk);
    reset = 1'b1;
    sw_p1 = 1'b0; sw_p2 = 1'b0; btn_start_n = 1'b1; clear = 1'b0; armed = arm;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (obs !== 8'h00) $display("FAIL reset_state: got %b want 00000000", obs);
    else passes++;
    reset = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_v) $display("FAIL reset_idle cyc%0d: got %b want %b", k, obs, exp_v);
      else passes++;
    end
  endtask

  task automatic test_clean_flip();
    int hit_edge = 0, hits = 0;
    do_reset(1'b1);
    sw_p1 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_v) $display("FAIL clean_model cyc%0d: got %b want %b", k, obs, exp_v);
      else passes++;
      if (p1_hit) begin hits++; if (hit_edge == 0) hit_edge = k; end
    end
    checks++;
    if (hit_edge != 7 || hits != 1) $display("FAIL clean_latency: got edge %0d count %0d want edge 7 count 1", hit_edge, hits);
    else passes++;
    checks++;
    if (winner !== 2'b01 || decided !== 1'b1) $display("FAIL clean_winner: got %b/%b want 01/1", winner, decided);
    else passes++;
  endtask

  task automatic test_glitch();
    int pulses = 0;
    do_reset(1'b1);
    sw_p2 = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_v) $display("FAIL glitch_model cyc%0d: got %b want %b", k, obs, exp_v);
      else passes++;
      pulses += int'(|obs[7:3]);
      if (k == 3) sw_p2 = 1'b0;
    end
    checks++;
    if (pulses != 0 || winner !== 2'b00) $display("FAIL glitch_reject: got pulses %0d winner %b want 0/00", pulses, winner);
    else passes++;
  endtask

  task automatic test_false_start();
    int f_edge = 0, fcount = 0, hits = 0;
    do_reset(1'b0);
    sw_p2 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_v) $display("FAIL false_model cyc%0d: got %b want %b", k, obs, exp_v);
      else passes++;
      if (p2_false) begin fcount++; if (f_edge == 0) f_edge = k; end
    end
    checks++;
    if (f_edge != 7 || fcount != 1) $display("FAIL false_latency: got edge %0d count %0d want edge 7 count 1", f_edge, fcount);
    else passes++;
    armed = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      hits += int'(p1_hit) + int'(p2_hit);
    end
    checks++;
    if (hits != 0 || winner !== 2'b00 || decided !== 1'b0) $display("FAIL held_switch_no_win: got hits %0d winner %b decided %b want 0/00/0", hits, winner, decided);
    else passes++;
  endtask

  task automatic test_tie();
    int pulses = 0;
    do_reset(1'b1);
    sw_p1 = 1'b1; sw_p2 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_v) $display("FAIL tie_model cyc%0d: got %b want %b", k, obs, exp_v);
      else passes++;
      pulses += int'(|obs[7:3]);
    end
    checks++;
    if (winner !== 2'b11 || decided !== 1'b1 || pulses != 0) $display("FAIL tie_result: got %b/%b pulses %0d want 11/1 pulses 0", winner, decided, pulses);
    else passes++;
    for (int k = 1; k <= 24; k++) begin
      if (k == 1) sw_p1 = 1'b0;
      if (k == 12) sw_p1 = 1'b1;
      @(negedge clk);
      pulses += int'(|obs[7:3]);
    end
    checks++;
    if (pulses != 0 || winner !== 2'b11) $display("FAIL tie_ignore: got pulses %0d winner %b want 0/11", pulses, winner);
    else passes++;
  endtask

  task automatic test_clear_start();
    int s_edge = 0, scount = 0;
    do_reset(1'b1);
    sw_p2 = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (winner !== 2'b10 || decided !== 1'b1) $display("FAIL p2_win: got %b/%b want 10/1", winner, decided);
    else passes++;
    sw_p1 = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_v) $display("FAIL clear_model cyc%0d: got %b want %b", k, obs, exp_v);
      else passes++;
      if (k == 7) begin
        checks++;
        if (obs !== 8'h00) $display("FAIL clear_priority: got %b want 00000000", obs);
        else passes++;
      end
      clear = (k == 6);
    end
    btn_start_n = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_v) $display("FAIL start_model cyc%0d: got %b want %b", k, obs, exp_v);
      else passes++;
      if (start_pulse) begin scount++; if (s_edge == 0) s_edge = k; end
    end
    checks++;
    if (s_edge != 7 || scount != 1) $display("FAIL start_latency: got edge %0d count %0d want edge 7 count 1", s_edge, scount);
    else passes++;
    btn_start_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset_mid_round();
    int hit_edge = 0;
    do_reset(1'b1);
    sw_p1 = 1'b1;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (obs !== 8'h00) $display("FAIL reset_mid_debounce: got %b want 00000000", obs);
    else passes++;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_v) $display("FAIL rst_model cyc%0d: got %b want %b", k, obs, exp_v);
      else passes++;
      if (p1_hit && hit_edge == 0) hit_edge = k;
    end
    checks++;
    if (hit_edge != 7) $display("FAIL rst_relatency: got edge %0d want 7", hit_edge);
    else passes++;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (obs !== 8'h00) $display("FAIL reset_after_win: got %b want 00000000", obs);
    else passes++;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sw_p1 = 1'b0;
  endtask

  task automatic test_random();
    do_reset(1'b0);
    for (int seg = 0; seg < 300; seg++) begin
      int dur;
      if ($urandom_range(0, 2) == 0) sw_p1 = ~sw_p1;
      if ($urandom_range(0, 2) == 0) sw_p2 = ~sw_p2;
      btn_start_n = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) armed = ($urandom_range(0, 3) != 0);
      clear = ($urandom_range(0, 15) == 0);
      dur = int'($urandom_range(1, 14));
      for (int k = 0; k < dur; k++) begin
        @(negedge clk);
        clear = 1'b0;
        checks++;
        if (obs !== exp_v) $display("FAIL random seg%0d cyc%0d: got %b want %b", seg, k, obs, exp_v);
        else passes++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_flip();
    test_glitch();
    test_false_start();
    test_tie();
    test_clear_start();
    test_reset_mid_round();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
